// File: rtl/vga_pkg.sv
// Shared VGA constants and the timing bundle type.
// No ports; imported by the compositor and its sub-modules.
package vga_pkg;

    localparam int RGB_W = 12;
    localparam int CNT_W = 11;
    localparam int TIM_W = 2 * CNT_W + 4;

    localparam logic [RGB_W-1:0] COLOR_BLACK = 12'h000;
    localparam logic [RGB_W-1:0] COLOR_WHITE = 12'hFFF;
    localparam logic [RGB_W-1:0] COLOR_RED   = 12'hF00;
    localparam logic [RGB_W-1:0] COLOR_GREEN = 12'h0F0;
    localparam logic [RGB_W-1:0] COLOR_BLUE  = 12'h00F;
    localparam logic [RGB_W-1:0] KEY_DEFAULT = 12'h000;

    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
    } timing_t;

endpackage

// File: rtl/delay.sv
// Fixed-latency register chain, used to carry the VGA timing bus.
// Ports: clk, rst (async active-low), din, dout = din delayed CLK_DEL cycles.
module delay #(
    parameter int WIDTH   = 26,
    parameter int CLK_DEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [CLK_DEL];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CLK_DEL; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < CLK_DEL; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/vga_layer_compositor_sel.sv
// Combinational highest-index layer select.
// Ports: layer_rgb/valid/bg_rgb in; rgb = winning colour, id = index or LAYERS.
module layer_priority_sel
    import vga_pkg::*;
#(
    parameter int LAYERS = 4,
    parameter int IDW    = $clog2(LAYERS + 1)
) (
    input  logic [RGB_W*LAYERS-1:0] layer_rgb,
    input  logic [LAYERS-1:0]       valid,
    input  logic [RGB_W-1:0]        bg_rgb,
    output logic [RGB_W-1:0]        rgb,
    output logic [IDW-1:0]          id
);

    // Ascending scan: the last hit is the highest index.
    always_comb begin
        rgb = bg_rgb;
        id  = IDW'(LAYERS);
        for (int k = 0; k < LAYERS; k++) begin
            if (valid[k]) begin
                rgb = layer_rgb[k*RGB_W +: RGB_W];
                id  = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/vga_layer_compositor.sv
// Two-stage compositor: background plus LAYERS overlays into one VGA stream,
// with frame-aligned layer enables and per-frame collision report.
// Ports: pclk, rst (async low); timing/bg/layer inputs; layer_en;
// delayed timing, rgb_out, top_layer_id, collision_out, frame_done.
module vga_layer_compositor
    import vga_pkg::*;
#(
    parameter int               LAYERS    = 4,
    parameter bit               KEY_EN    = 1'b1,
    parameter logic [RGB_W-1:0] KEY_COLOR = KEY_DEFAULT,
    parameter int               IDW       = $clog2(LAYERS + 1)
) (
    input  logic                    pclk,
    input  logic                    rst,
    input  logic [CNT_W-1:0]        hcount_in,
    input  logic [CNT_W-1:0]        vcount_in,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    hblnk_in,
    input  logic                    vblnk_in,
    input  logic [RGB_W-1:0]        bg_rgb_in,
    input  logic [RGB_W*LAYERS-1:0] layer_rgb_in,
    input  logic [LAYERS-1:0]       layer_valid_in,
    input  logic [LAYERS-1:0]       layer_en,
    output logic [CNT_W-1:0]        hcount_out,
    output logic [CNT_W-1:0]        vcount_out,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic                    hblnk_out,
    output logic                    vblnk_out,
    output logic [RGB_W-1:0]        rgb_out,
    output logic [IDW-1:0]          top_layer_id,
    output logic [LAYERS-1:0]       collision_out,
    output logic                    frame_done
);

    timing_t tim_in;
    timing_t tim_out;

    assign tim_in = '{hcount: hcount_in, vcount: vcount_in,
                      hsync: hsync_in, vsync: vsync_in,
                      hblnk: hblnk_in, vblnk: vblnk_in};

    delay #(.WIDTH(TIM_W), .CLK_DEL(2)) u_tim_delay (
        .clk  (pclk),
        .rst  (rst),
        .din  (tim_in),
        .dout (tim_out)
    );

    assign hcount_out = tim_out.hcount;
    assign vcount_out = tim_out.vcount;
    assign hsync_out  = tim_out.hsync;
    assign vsync_out  = tim_out.vsync;
    assign hblnk_out  = tim_out.hblnk;
    assign vblnk_out  = tim_out.vblnk;

    logic                    hblnk_s1;
    logic                    vblnk_s1;
    logic [RGB_W-1:0]        bg_s1;
    logic [RGB_W*LAYERS-1:0] rgb_s1;
    logic [LAYERS-1:0]       valid_s1;
    logic [LAYERS-1:0]       en_active;

    // Enables are latched only as vertical blanking starts, so a change
    // never splits a frame.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hblnk_s1  <= 1'b0;
            vblnk_s1  <= 1'b0;
            bg_s1     <= '0;
            rgb_s1    <= '0;
            valid_s1  <= '0;
            en_active <= '1;
        end else begin
            hblnk_s1 <= hblnk_in;
            vblnk_s1 <= vblnk_in;
            bg_s1    <= bg_rgb_in;
            rgb_s1   <= layer_rgb_in;
            valid_s1 <= layer_valid_in;
            if (vblnk_in && !vblnk_s1) en_active <= layer_en;
        end
    end

    logic [LAYERS-1:0] key_hit;
    logic [LAYERS-1:0] eff_valid;
    logic [LAYERS-1:0] rest_valid;
    logic [RGB_W-1:0]  win_rgb;
    logic [IDW-1:0]    win_id;
    logic [RGB_W-1:0]  unused_rest_rgb;
    logic [IDW-1:0]    rest_id;
    logic              multi;
    logic              blank;
    logic              boundary;

    always_comb begin
        key_hit = '0;
        for (int k = 0; k < LAYERS; k++) begin
            key_hit[k] = KEY_EN && (rgb_s1[k*RGB_W +: RGB_W] == KEY_COLOR);
        end
    end

    assign eff_valid = valid_s1 & en_active & ~key_hit;

    layer_priority_sel #(.LAYERS(LAYERS), .IDW(IDW)) u_sel (
        .layer_rgb (rgb_s1),
        .valid     (eff_valid),
        .bg_rgb    (bg_s1),
        .rgb       (win_rgb),
        .id        (win_id)
    );

    // Drop the winner; anything left means two or more layers overlap,
    // and then every effective layer on this pixel is colliding.
    always_comb begin
        rest_valid = '0;
        for (int k = 0; k < LAYERS; k++) begin
            rest_valid[k] = eff_valid[k] && (win_id != IDW'(k));
        end
    end

    layer_priority_sel #(.LAYERS(LAYERS), .IDW(IDW)) u_multi (
        .layer_rgb (rgb_s1),
        .valid     (rest_valid),
        .bg_rgb    (bg_s1),
        .rgb       (unused_rest_rgb),
        .id        (rest_id)
    );

    assign multi    = (rest_id != IDW'(LAYERS));
    assign blank    = hblnk_s1 | vblnk_s1;
    assign boundary = vblnk_s1 & ~tim_out.vblnk;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            rgb_out      <= '0;
            top_layer_id <= IDW'(LAYERS);
            frame_done   <= 1'b0;
        end else begin
            rgb_out      <= blank ? '0 : win_rgb;
            top_layer_id <= blank ? IDW'(LAYERS) : win_id;
            frame_done   <= boundary;
        end
    end

    generate
        if (LAYERS > 1) begin : g_coll
            logic [LAYERS-1:0] acc;

            always_ff @(posedge pclk or negedge rst) begin
                if (!rst) begin
                    acc           <= '0;
                    collision_out <= '0;
                end else if (boundary) begin
                    collision_out <= acc;
                    acc           <= '0;
                end else if (!blank && multi) begin
                    acc <= acc | eff_valid;
                end
            end
        end else begin : g_nocoll
            assign collision_out = '0;
        end
    endgenerate

endmodule
